// File: rtl/coeff_unpack.sv
// -----------------------------------------------------------------------------
// coeff_unpack
//
// ByteDecode_d unpacker. Consumes one polynomial as a packed little-endian
// stream of IN_W-bit words (N_COEFF coefficients of d bits each, stream bit p =
// word[p/IN_W] bit p%IN_W) and emits NUM zero-extended coefficients per output
// beat. Beat b, lane k carries coefficient b*NUM + k.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse, begins one polynomial (ignored while busy)
//   d_sel      coefficient width d; legal values 1, 4, 5, 10, 11, 12
//   in_data    packed input word
//   in_valid   in_data valid
//   in_ready   block accepts a word this cycle
//   out_data   NUM lanes, lane k at [k*WIDTH +: WIDTH]
//   out_valid  out_data valid
//   out_ready  consumer accepts the beat
//   busy       polynomial in progress
//   done       one-cycle pulse after the last beat is accepted
//   err        sticky error: illegal d_sel at start, leftover buffer bits at
//              the end of a polynomial, or (optional) out-of-range coefficient
//   mod_flag   (optional) per-lane "coefficient >= 3329" flag, registered with
//              out_data
//
// Optional feature: define COEFF_UNPACK_MODCHK_EN to enable the d=12 modulus
// check and the mod_flag output. Data always passes through unmodified.
// -----------------------------------------------------------------------------
module coeff_unpack #(
    parameter int NUM     = 4,
    parameter int WIDTH   = 32,
    parameter int IN_W    = 32,
    parameter int N_COEFF = 256,
    parameter int BUF_W   = 96
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             d_sel,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NUM*WIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
`ifdef COEFF_UNPACK_MODCHK_EN
    ,
    output logic [NUM-1:0]         mod_flag
`endif
);

    localparam int CNT_W   = $clog2(BUF_W + 1);
    localparam int N_BEATS = N_COEFF / NUM;
    localparam int BEAT_W  = $clog2(N_BEATS + 1);
    localparam int WORD_W  = $clog2(N_COEFF * 12 / IN_W + 1);

    // A word may only be accepted if it fits entirely above the current fill.
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(BUF_W - IN_W);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             d_q, d_d;
    logic [BUF_W-1:0]       buf_q, buf_d;
    logic [CNT_W-1:0]       fill_q, fill_d;
    logic [WORD_W-1:0]      words_q, words_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [NUM*WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   run;
    logic                   accept;
    logic                   out_fire;
    logic                   finishing;
    logic                   load;
    logic                   d_sel_legal;
    logic [CNT_W-1:0]       beat_bits;
    logic [WORD_W-1:0]      word_limit;
    logic [11:0]            coeff_mask;
    logic [BUF_W-1:0]       merged_buf;
    logic [CNT_W-1:0]       merged_fill;
    logic [11:0]            lane_coeff [NUM];
    logic [NUM*WIDTH-1:0]   beat_data;
    logic [NUM-1:0]         lane_oor;

`ifdef COEFF_UNPACK_MODCHK_EN
    logic [NUM-1:0]         mod_flag_q, mod_flag_d;
`endif

    always_comb begin : legal_check
        unique case (d_sel)
            4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: d_sel_legal = 1'b1;
            default:                               d_sel_legal = 1'b0;
        endcase
    end

    assign run        = (state_q == S_RUN);
    assign beat_bits  = CNT_W'(NUM) * CNT_W'(d_q);
    assign word_limit = WORD_W'(N_COEFF / IN_W) * WORD_W'(d_q);
    assign coeff_mask = 12'((13'd1 << d_q) - 13'd1);

    assign in_ready  = run && (fill_q <= FILL_MAX) && (words_q < word_limit);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign finishing = run && out_fire && (beat_q == BEAT_W'(N_BEATS - 1));

    // The incoming word is merged into the buffer before beat formation, so a
    // word accepted in cycle t can already be emitted as out_valid in t+1, and
    // a simultaneous accept and consume cannot drop bits.
    always_comb begin : merge
        merged_buf  = buf_q;
        merged_fill = fill_q;
        if (accept) begin
            merged_buf  = buf_q | (BUF_W'(in_data) << fill_q);
            merged_fill = fill_q + CNT_W'(IN_W);
        end
    end

    assign load = run && !finishing && (merged_fill >= beat_bits)
                  && (!out_valid_q || out_ready);

    always_comb begin : lane_extract
        beat_data = '0;
        lane_oor  = '0;
        for (int k = 0; k < NUM; k++) begin
            lane_coeff[k] = 12'(merged_buf >> (CNT_W'(k) * CNT_W'(d_q))) & coeff_mask;
            beat_data[k*WIDTH +: WIDTH] = WIDTH'(lane_coeff[k]);
`ifdef COEFF_UNPACK_MODCHK_EN
            lane_oor[k] = (d_q == 4'd12) && (lane_coeff[k] >= 12'd3329);
`endif
        end
    end

    always_comb begin : next_state
        // NOTE: every variable gets its hold/default value first so that no
        // path through the case below can leave it unassigned (no latches).
        state_d     = state_q;
        d_d         = d_q;
        buf_d       = buf_q;
        fill_d      = fill_q;
        words_d     = words_q;
        beat_d      = beat_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        err_d       = err_q;
`ifdef COEFF_UNPACK_MODCHK_EN
        mod_flag_d  = mod_flag_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                out_valid_d = 1'b0;
                if (start) begin
                    if (d_sel_legal) begin
                        state_d = S_RUN;
                        d_d     = d_sel;
                        buf_d   = '0;
                        fill_d  = '0;
                        words_d = '0;
                        beat_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                buf_d  = load ? (merged_buf >> beat_bits) : merged_buf;
                fill_d = load ? (merged_fill - beat_bits) : merged_fill;
                if (accept) begin
                    words_d = words_q + WORD_W'(1);
                end
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    beat_d      = beat_q + BEAT_W'(1);
                end
                if (load) begin
                    out_data_d  = beat_data;
                    out_valid_d = 1'b1;
`ifdef COEFF_UNPACK_MODCHK_EN
                    mod_flag_d  = lane_oor;
`endif
                    if (lane_oor != '0) begin
                        err_d = 1'b1;
                    end
                end
                if (finishing) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    out_valid_d = 1'b0;
                    // A polynomial is exactly 8*d words, so every bit must
                    // have been consumed by the final beat.
                    if (fill_d != '0) begin
                        err_d = 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            d_q         <= '0;
            // NOTE: the bit buffer is cleared, not just invalidated: new words
            // are OR-merged above the fill point, which relies on every bit
            // above fill being zero.
            buf_q       <= '0;
            fill_q      <= '0;
            words_q     <= '0;
            beat_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef COEFF_UNPACK_MODCHK_EN
            mod_flag_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            words_q     <= words_d;
            beat_q      <= beat_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef COEFF_UNPACK_MODCHK_EN
            mod_flag_q  <= mod_flag_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = run;
    assign done      = done_q;
    assign err       = err_q;
`ifdef COEFF_UNPACK_MODCHK_EN
    assign mod_flag  = mod_flag_q;
`endif

endmodule

// File: tb/tb_coeff_unpack.sv
// -----------------------------------------------------------------------------
// tb_coeff_unpack
//
// Directed sequence of polynomials through coeff_unpack with randomized word
// data and handshake timing. Expected beats come from a bit-level ByteDecode_d
// model over the stimulus word list (coefficient i = stream bits [i*d +: d]).
// Compile with COEFF_UNPACK_MODCHK_EN to also exercise the modulus check.
// -----------------------------------------------------------------------------
module tb_coeff_unpack;

    localparam int NUM     = 4;
    localparam int WIDTH   = 32;
    localparam int N_BEATS = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [3:0]           d_sel;
    logic [31:0]          in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM*WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;
    logic                 err;
`ifdef COEFF_UNPACK_MODCHK_EN
    logic [NUM-1:0]       mod_flag;
    logic [NUM-1:0]       first_flag;
`endif

    int                   checks = 0;
    int                   errors = 0;
    logic                 exp_err = 1'b0;
    logic [31:0]          stim_words [$];
    logic [NUM*WIDTH-1:0] first_beat;
    int                   beats_seen;

    coeff_unpack dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .d_sel     (d_sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef COEFF_UNPACK_MODCHK_EN
        ,
        .mod_flag  (mod_flag)
`endif
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: coefficient i is stream bits [i*d +: d].
    function automatic logic [31:0] model_coeff(input int d, input int i);
        logic [31:0] c;
        logic [31:0] w;
        int          p;
        c = '0;
        for (int j = 0; j < d; j++) begin
            p    = i * d + j;
            w    = stim_words[p / 32];
            c[j] = w[p % 32];
        end
        return c;
    endfunction

    function automatic logic [NUM*WIDTH-1:0] model_beat(input int d, input int b);
        logic [NUM*WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NUM; k++) begin
            r[k*WIDTH +: WIDTH] = model_coeff(d, b * NUM + k);
        end
        return r;
    endfunction

    function automatic logic [NUM-1:0] model_flag(input int d, input int b);
        logic [NUM-1:0] f;
        f = '0;
        for (int k = 0; k < NUM; k++) begin
            f[k] = (d == 12) && (model_coeff(d, b * NUM + k) >= 32'd3329);
        end
        return f;
    endfunction

    task automatic fill_random(input int n);
        stim_words.delete();
        repeat (n) stim_words.push_back($urandom);
    endtask

    task automatic reset_and_check(input string tag);
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        exp_err = 1'b0;
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_err"},       err,       0);
        rst = 1'b0;
    endtask

    // Runs one polynomial of width d from stim_words. restart_at >= 0 pulses a
    // second start at that loop cycle; abort_at >= 0 stops after that many
    // accepted beats without waiting for done.
    task automatic run_poly(input int d, input int ready_pct, input int valid_pct,
                            input int restart_at, input int abort_at);
        int                   n;
        int                   total;
        int                   widx;
        int                   bidx;
        int                   cyc;
        bit                   stalled;
        bit                   ir_checked;
        logic [NUM*WIDTH-1:0] held;
        n          = stim_words.size();
        total      = (abort_at >= 0) ? abort_at : N_BEATS;
        widx       = 0;
        bidx       = 0;
        cyc        = 0;
        stalled    = 1'b0;
        ir_checked = 1'b0;
        held       = '0;

        @(negedge clk);
        d_sel = 4'(d);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("busy_after_start_d%0d", d), busy, 1);

        while (bidx < total && cyc < 4000) begin
            if (stalled) begin
                check($sformatf("stall_hold_d%0d_b%0d", d, bidx), {out_valid, out_data}, {1'b1, held});
            end
            start = (cyc == restart_at);
            if (start) d_sel = 4'd12;
            in_valid  = (widx < n) && ($urandom_range(99) < valid_pct);
            in_data   = in_valid ? stim_words[widx] : $urandom;
            out_ready = ($urandom_range(99) < ready_pct);
            if (widx == n && !ir_checked) begin
                check($sformatf("in_ready_after_last_d%0d", d), in_ready, 0);
                ir_checked = 1'b1;
            end
            if (in_valid && in_ready) widx++;
            if (out_valid && out_ready) begin
                check($sformatf("beat%0d_d%0d", bidx, d), out_data, model_beat(d, bidx));
`ifdef COEFF_UNPACK_MODCHK_EN
                check($sformatf("flag%0d_d%0d", bidx, d), mod_flag, model_flag(d, bidx));
                if (model_flag(d, bidx) != '0) exp_err = 1'b1;
                if (bidx == 0) first_flag = mod_flag;
`endif
                if (bidx == 0) first_beat = out_data;
                bidx++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            @(negedge clk);
            cyc++;
        end

        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        beats_seen = bidx;
        check($sformatf("beat_budget_d%0d", d), bidx, total);
        if (abort_at < 0) begin
            check($sformatf("done_pulse_d%0d", d),    done,      1);
            check($sformatf("busy_at_done_d%0d", d),  busy,      0);
            check($sformatf("valid_at_done_d%0d", d), out_valid, 0);
            check($sformatf("err_at_done_d%0d", d),   err,       exp_err);
            @(negedge clk);
            check($sformatf("done_clears_d%0d", d),   done,      0);
        end
    endtask

    initial begin : main
        int          mod_coeffs [4];
        int          p;
        logic [31:0] w;

        rst       = 1'b1;
        start     = 1'b0;
        d_sel     = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset_and_check("por");

        // Bit order, d=12.
        stim_words.delete();
        stim_words.push_back(32'h23456789);
        stim_words.push_back(32'h0000000F);
        stim_words.push_back(32'h00000000);
        repeat (93) stim_words.push_back($urandom);
        run_poly(12, 100, 100, -1, -1);
        check("bitorder_beat0", first_beat, {32'h0, 32'hF23, 32'h456, 32'h789});

        // Full polynomial, d=1, no backpressure.
        stim_words.delete();
        repeat (8) stim_words.push_back(32'hA5A5A5A5);
        run_poly(1, 100, 100, -1, -1);
        check("d1_beat0", first_beat, {32'd0, 32'd1, 32'd0, 32'd1});
        check("d1_beats", beats_seen, 64);

        // Backpressure, d=11.
        fill_random(88);
        run_poly(11, 30, 60, -1, -1);
        check("d11_beats", beats_seen, 64);

        // Illegal width.
        @(negedge clk);
        d_sel = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("illegal_err",  err,  1);
        check("illegal_busy", busy, 0);
        reset_and_check("after_illegal");

        // Second start while busy is ignored.
        fill_random(32);
        run_poly(4, 70, 80, 3, -1);
        check("d4_beats", beats_seen, 64);

        // Reset mid-polynomial after 20 beats.
        fill_random(80);
        run_poly(10, 60, 80, -1, 20);
        reset_and_check("mid_reset");

        // Fresh polynomial after reset.
        fill_random(40);
        run_poly(5, 50, 70, -1, -1);
        check("d5_beats", beats_seen, 64);

        // Modulus stream, d=12: 3328, 3329, 4095, 0, then zeros.
        mod_coeffs = '{3328, 3329, 4095, 0};
        stim_words.delete();
        repeat (96) stim_words.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 12; j++) begin
                if (((mod_coeffs[i] >> j) & 1) != 0) begin
                    p = i * 12 + j;
                    w = stim_words[p / 32];
                    w[p % 32] = 1'b1;
                    stim_words[p / 32] = w;
                end
            end
        end
        run_poly(12, 80, 90, -1, -1);
        check("mod_beat0", first_beat, {32'd0, 32'd4095, 32'd3329, 32'd3328});
`ifdef COEFF_UNPACK_MODCHK_EN
        check("mod_flag0", first_flag, 4'b0110);
        check("mod_err",   err,        1);
`else
        check("nomod_err", err,        0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coeff_unpack.md
Name: coeff_unpack

Overview:
- ByteDecode_d unpacker; the decode-side counterpart of the PE compress path.
- Takes a packed little-endian 32-bit word stream of one polynomial (256 coefficients, d bits each) and emits NUM zero-extended coefficients per beat.
- Output feeds the pe_array lanes ahead of DCMP-d / DCP instructions.
- Sits between the memory/stream reader and the PE input mux.

Parameters:
- NUM, 4, coefficients per output beat (PE lanes); must divide N_COEFF.
- WIDTH, 32, output coefficient width; coefficient is zero-extended.
- IN_W, 32, input word width.
- N_COEFF, 256, coefficients per polynomial.
- BUF_W, 96, bit-buffer capacity; must be at least NUM*12 + IN_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins one polynomial
- d_sel  in  4  coefficient bit width d; legal values 1, 4, 5, 10, 11, 12
- in_data  in  IN_W  packed word
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts word
- out_data  out  NUM*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts beat
- busy  out  1  polynomial in progress
- done  out  1  one-cycle pulse after last beat accepted
- err  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, err=0. Bit buffer, fill count, word counter and beat counter are all cleared.
- FSM IDLE:
  - start with legal d_sel: latch d, clear counters and fill, go to RUN, busy=1.
  - start with illegal d_sel: err<=1, stay IDLE.
  - start while busy: ignored.
- Bit order (FIPS 203):
  - Stream bit p = word[p/32] bit (p%32).
  - Coefficient i = stream bits [i*d +: d].
  - Beat b lane k carries coefficient b*NUM+k.
- Buffer: shift-right bit buffer. New words are appended at bit position fill; a beat consumes the low NUM*d bits.
- in_ready = RUN && fill + IN_W <= BUF_W && words_in < 8*d. Total words per polynomial = N_COEFF*d/32 = 8d, so a polynomial always ends on a word boundary.
- Beat formation: when fill >= NUM*d and the output register is empty or being drained in the same cycle, load out_data from the buffer and set out_valid.
- Accept and consume in the same cycle: fill_next = fill + 32*accept - NUM*d*consume. A simultaneous accept and consume is legal and must not lose bits.
- Output hold: out_data and out_valid hold stable while out_valid && !out_ready.
- Latency: a word accepted at cycle t can produce a beat with out_valid at t+1, at the earliest.
- Beat counter: counts accepted output beats. When it reaches N_COEFF/NUM:
  - go to IDLE and pulse done for 1 cycle;
  - busy drops in the same cycle as done;
  - fill must be 0; nonzero fill sets err.
- In IDLE: in_ready=0 and out_valid=0.
- Upper bits of each lane beyond d are always 0.
- Reset mid-polynomial: everything returns to reset values on the next edge; no done pulse.
- err clears only on rst.

Optional Feature:
- Macro: COEFF_UNPACK_MODCHK_EN.
- Defined:
  - When d=12, each emitted lane is compared against Q=3329; any coefficient >= 3329 sets err (sticky).
  - Adds output mod_flag [NUM-1:0], registered with out_data, with bit k = lane k out of range.
  - Data still passes unmodified.
- Undefined: no comparison and no mod_flag port; d=12 values pass through without any check.

Test Plan:
- Bit order, d=12:
  - Stimulus: start, d_sel=12; word0=0x23456789, word1=0x0000000F, word2=0.
  - Response: beat 0 lanes = 0x789, 0x456, 0xF23, 0x000.
- Full polynomial, d=1:
  - Stimulus: 8 words of 0xA5A5A5A5, out_ready held at 1.
  - Response: 64 beats; beat 0 = {1,0,1,0}, beat 1 = {0,1,0,1}, pattern repeating; done one cycle after beat 63; busy=0; err=0.
- Backpressure, d=11:
  - Stimulus: 88 random words; out_ready toggles with a 30% duty cycle; in_valid random.
  - Response: beats match a software ByteDecode_11 model; out_data stable whenever stalled; exactly 64 beats; in_ready=0 after word 88.
- Illegal width and busy start:
  - Stimulus: start with d_sel=7.
  - Response: err=1, busy stays 0.
  - Stimulus: start with d_sel=4 followed by a second start 3 cycles later.
  - Response: second start ignored; 32 words in produce 64 beats.
- Reset mid-operation:
  - Stimulus: d_sel=10; assert rst after 20 beats.
  - Response: next cycle all outputs 0, no done pulse.
  - Stimulus: a new start with d_sel=5.
  - Response: decodes the full polynomial correctly.
- Modulus check, macro defined:
  - Stimulus: d=12; coefficient stream 3328, 3329, 4095, 0.
  - Response: mod_flag = 4'b0110, err=1, data unchanged.
  - Without the macro: err stays 0.
